// File: rtl/ssemi_decim_out_fifo.sv
// ---------------------------------------------------------------------------
// ssemi_decim_out_fifo
//
// Output buffer placed directly after the ADC decimator. Decimated samples
// enter through a valid/ready pair. The ready output applies backpressure to
// the decimator. Samples leave towards the host/DMA side as a
// first-word-fall-through stream. The block also reports its fill level, a
// programmable watermark interrupt, and a sticky overflow flag with a
// saturating drop counter.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_decim_valid/i_decim_data     sample input from the decimator
//   o_decim_ready                  FIFO can take a sample (not full, not in reset)
//   o_rd_valid/o_rd_data           head entry of the FIFO (FWFT)
//   i_rd_ready                     consumer pops the head entry
//   i_flush                        empties the FIFO at the next edge
//   i_watermark                    interrupt threshold, 0 disables it
//   i_clr_ovf                      clears the overflow flag and the drop counter
//   o_level                        occupancy, 0..DEPTH
//   o_wm_irq                       level interrupt, set while occupancy >= watermark
//   o_overflow, o_drop_cnt         sticky drop flag and saturating drop count
// ---------------------------------------------------------------------------
`ifndef SSEMI_DATA_WIDTH
`define SSEMI_DATA_WIDTH 24
`endif

module ssemi_decim_out_fifo #(
  parameter int DATA_WIDTH = `SSEMI_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_decim_valid,
  input  logic [DATA_WIDTH-1:0] i_decim_data,
  output logic                  o_decim_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  input  logic                  i_flush,
  input  logic [AW:0]           i_watermark,
  input  logic                  i_clr_ovf,
  output logic [AW:0]           o_level,
  output logic                  o_wm_irq,
  output logic                  o_overflow,
  output logic [15:0]           o_drop_cnt
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  wm_irq_q, wm_irq_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic full;
  logic wr_en;
  logic rd_en;
  logic drop;

  // Handshake decode. Ready depends only on the registered count and on the
  // reset. A pop in the same cycle therefore never opens ready when the FIFO
  // is full, and no combinational path runs from i_rd_ready back to the
  // decimator. A flush suppresses the drop as well: the FIFO is being
  // discarded on purpose, so the lost sample is not an overflow.
  assign full          = (cnt_q == FullCount);
  assign o_decim_ready = i_rst_n & ~full;
  assign o_rd_valid    = (cnt_q != '0);
  assign o_rd_data     = mem_q[rd_ptr_q];
  assign wr_en         = i_decim_valid & o_decim_ready;
  assign rd_en         = o_rd_valid & i_rd_ready;
  assign drop          = i_rst_n & i_decim_valid & full & ~i_flush;

  assign o_level    = cnt_q;
  assign o_wm_irq   = wm_irq_q;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_cnt_q;

  // Next-state logic for the pointers, count, watermark and overflow state.
  // A flush wins over any push or pop in the same cycle. The watermark
  // compares against the next count, so the interrupt moves on the same
  // edge as o_level. When a clear and a drop arrive together, the drop is
  // the one that sticks.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_en && !rd_en) begin
        cnt_d = cnt_q + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
        cnt_d = cnt_q - (AW+1)'(1);
      end
    end

    if (i_clr_ovf) begin
      ovf_d      = drop;
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    wm_irq_d = (i_watermark != '0) && (cnt_d >= i_watermark);
  end

  // Control state register with a synchronous active-low reset. The reset
  // clears everything, even in the middle of a stream.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wm_irq_q   <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      wm_irq_q   <= wm_irq_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Sample storage. It has no reset because stale entries are hidden
  // behind o_rd_valid. A sample that arrives in the same cycle as a flush
  // is not stored.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_flush) begin
      mem_q[wr_ptr_q] <= i_decim_data;
    end
  end

endmodule

// File: tb/tb_ssemi_decim_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_ssemi_decim_out_fifo
//
// Directed self-checking bench for ssemi_decim_out_fifo with DEPTH=16 and
// 24-bit samples. Inputs are driven 1 time unit after each rising edge, and
// outputs are sampled at the same point. Every expected value is computed
// by hand in the stimulus below.
// ---------------------------------------------------------------------------
module tb_ssemi_decim_out_fifo;

  localparam int DataWidth = 24;
  localparam int Depth     = 16;
  localparam int Aw        = 4;

  logic                 clock;
  logic                 rstN;
  logic                 decimValid;
  logic [DataWidth-1:0] decimData;
  logic                 decimReady;
  logic                 rdValid;
  logic [DataWidth-1:0] rdData;
  logic                 rdReady;
  logic                 flush;
  logic [Aw:0]          watermark;
  logic                 clrOvf;
  logic [Aw:0]          level;
  logic                 wmIrq;
  logic                 overflow;
  logic [15:0]          dropCnt;

  int checkCount = 0;
  int errorCount = 0;

  ssemi_decim_out_fifo #(
    .DATA_WIDTH(DataWidth),
    .DEPTH     (Depth)
  ) dut (
    .i_clk        (clock),
    .i_rst_n      (rstN),
    .i_decim_valid(decimValid),
    .i_decim_data (decimData),
    .o_decim_ready(decimReady),
    .o_rd_valid   (rdValid),
    .o_rd_data    (rdData),
    .i_rd_ready   (rdReady),
    .i_flush      (flush),
    .i_watermark  (watermark),
    .i_clr_ovf    (clrOvf),
    .o_level      (level),
    .o_wm_irq     (wmIrq),
    .o_overflow   (overflow),
    .o_drop_cnt   (dropCnt)
  );

  // 10 time-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compares one observed value against its expected value and counts the
  // comparison. A mismatch prints a FAIL line and is added to the error count.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, waits for the rising edge, then waits 1 time
  // unit so that registered outputs have settled.
  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic rdy, input logic fl, input logic clr);
    decimValid = valid;
    decimData  = data[DataWidth-1:0];
    rdReady    = rdy;
    flush      = fl;
    clrOvf     = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    rstN       = 1'b0;
    decimValid = 1'b0;
    decimData  = '0;
    rdReady    = 1'b0;
    flush      = 1'b0;
    watermark  = '0;
    clrOvf     = 1'b0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_ready", decimReady, 0);
    checkOutput("rst_valid", rdValid, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_irq", wmIrq, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_drop", dropCnt, 0);
    rstN = 1'b1;
    #1;
    checkOutput("rel_ready", decimReady, 1);

    // Fill 1..16 with the watermark at DEPTH, then drain in order
    watermark = 5'd16;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, i, 0, 0, 0);
      checkOutput("fill_level", level, i);
      checkOutput("fill_ready", decimReady, (i < 16) ? 1 : 0);
      checkOutput("fill_irq", wmIrq, (i == 16) ? 1 : 0);
      if (i == 1) checkOutput("fill_first", rdData, 1);
    end
    for (int i = 1; i <= 16; i++) begin
      checkOutput("drain_valid", rdValid, 1);
      checkOutput("drain_data", rdData, i);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("drain_level", level, 16 - i);
      if (i == 1) begin
        checkOutput("drain_ready", decimReady, 1);
        checkOutput("drain_irq", wmIrq, 0);
      end
    end
    checkOutput("drain_empty", rdValid, 0);
    watermark = '0;

    // Simultaneous read and write at level 8, across pointer wrap
    for (int k = 0; k < 8; k++) applyStimulus(1, 32'h100 + k, 0, 0, 0);
    for (int c = 0; c < 100; c++) begin
      checkOutput("rw_data", rdData, 32'h100 + c);
      applyStimulus(1, 32'h108 + c, 1, 0, 0);
      checkOutput("rw_level", level, 8);
    end
    for (int k = 0; k < 8; k++) begin
      checkOutput("rw_tail", rdData, 32'h100 + 100 + k);
      applyStimulus(0, 0, 1, 0, 0);
    end
    checkOutput("rw_empty", level, 0);

    // Overflow with a watermark above DEPTH that must never fire
    watermark = 5'd20;
    for (int k = 0; k < 16; k++) applyStimulus(1, 32'h200 + k, 0, 0, 0);
    checkOutput("ovf_irq", wmIrq, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 32'hDEAD, 0, 0, 0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_drop5", dropCnt, 5);
    checkOutput("ovf_level", level, 16);
    checkOutput("ovf_head", rdData, 32'h200);
    rdReady = 1'b1;
    #1;
    checkOutput("ovf_ready_nocomb", decimReady, 0);
    applyStimulus(1, 32'hBEEF, 0, 0, 1);
    checkOutput("clr_drop_flag", overflow, 1);
    checkOutput("clr_drop_cnt", dropCnt, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_flag", overflow, 0);
    checkOutput("clr_cnt", dropCnt, 0);
    for (int k = 0; k < 16; k++) begin
      checkOutput("ovf_contents", rdData, 32'h200 + k);
      applyStimulus(0, 0, 1, 0, 0);
    end
    watermark = '0;

    // Watermark 4: rises on the 4th write, falls on the first read
    watermark = 5'd4;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, k, 0, 0, 0);
      checkOutput("wm_irq", wmIrq, (k == 4) ? 1 : 0);
    end
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wm_fall", wmIrq, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0, 0);
    watermark = '0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, k, 0, 0, 0);
      checkOutput("wm0_irq", wmIrq, 0);
    end
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 0, 0);

    // Flush at level 10 with a simultaneous write and read
    for (int k = 0; k < 10; k++) applyStimulus(1, 32'h300 + k, 0, 0, 0);
    checkOutput("fl_pre_level", level, 10);
    applyStimulus(1, 32'h3FF, 1, 1, 0);
    checkOutput("fl_level", level, 0);
    checkOutput("fl_valid", rdValid, 0);
    checkOutput("fl_ready", decimReady, 1);
    checkOutput("fl_ovf", overflow, 0);
    checkOutput("fl_drop", dropCnt, 0);
    applyStimulus(1, 32'h3AA, 0, 0, 0);
    checkOutput("fl_after", rdData, 32'h3AA);
    applyStimulus(0, 0, 1, 0, 0);

    // Reset mid-operation with level 7 and overflow set
    for (int k = 0; k < 16; k++) applyStimulus(1, 32'h400 + k, 0, 0, 0);
    applyStimulus(1, 32'hDEAD, 0, 0, 0);
    for (int k = 0; k < 9; k++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("mid_level", level, 7);
    checkOutput("mid_ovf", overflow, 1);
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_rst_ready", decimReady, 0);
    checkOutput("mid_rst_valid", rdValid, 0);
    checkOutput("mid_rst_level", level, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    checkOutput("mid_rst_drop", dropCnt, 0);
    checkOutput("mid_rst_irq", wmIrq, 0);
    rstN = 1'b1;
    #1;
    checkOutput("mid_rel_ready", decimReady, 1);
    applyStimulus(1, 32'h4AA, 0, 0, 0);
    checkOutput("mid_rel_data", rdData, 32'h4AA);
    checkOutput("mid_rel_level", level, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
